// File: rtl/axis_mem_reader.sv
// Replays cmd_len+1 words from a sync-read memory as one AXI-Stream frame; first tvalid 3 cycles after cmd accept.
// Reads are credit-limited to the 2-entry output buffer, so any tready pattern stalls reads without loss.
module axis_mem_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [LEN_WIDTH:0]    LEN_ONE  = (LEN_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [LEN_WIDTH:0]      rd_remaining;
    logic [LEN_WIDTH:0]      tx_remaining;
    logic                    inflight;
    logic                    inflight_last;
    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic [1:0]              fifo_last;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic [1:0]              occ;
    logic                    done_q;
    logic                    push;
    logic                    pop;

    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = fifo_data[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];
    assign m_axis_tuser  = 1'b0;
    assign mem_rd_addr   = rd_addr;
    assign busy          = (state != IDLE);
    assign done          = done_q;

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign push = inflight;
    // Credit counts the read still in flight so returned data always has a slot.
    assign occ  = count + {1'b0, inflight};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                mem_rd_en = (rd_remaining != '0) && ((occ < 2'd2) || pop);
                if (mem_rd_en && (rd_remaining == LEN_ONE)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (tx_remaining == LEN_ONE)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr       <= '0;
            rd_remaining  <= '0;
            tx_remaining  <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            inflight      <= mem_rd_en;
            inflight_last <= mem_rd_en && (rd_remaining == LEN_ONE);

            if (cmd_valid && cmd_ready) begin
                rd_addr      <= cmd_addr;
                rd_remaining <= {1'b0, cmd_len} + LEN_ONE;
                tx_remaining <= {1'b0, cmd_len} + LEN_ONE;
            end

            if (mem_rd_en) begin
                rd_addr      <= rd_addr + ADDR_ONE;
                rd_remaining <= rd_remaining - LEN_ONE;
            end

            if (push) begin
                fifo_data[wr_ptr] <= mem_rd_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end

            if (pop) begin
                rd_ptr       <= ~rd_ptr;
                tx_remaining <= tx_remaining - LEN_ONE;
                if (tx_remaining == LEN_ONE) begin
                    done_q <= 1'b1;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_mem_reader.sv
// Scoreboard bench for axis_mem_reader: expected beats and read addresses are queued per command.
module tb_axis_mem_reader;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int LW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          busy;
    logic          done;

    axis_mem_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            checks = 0;
    int            passed = 0;
    bit            mon_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         mon_beat;
    logic [AW-1:0] mon_addr;

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_rd_en) begin
                checks++;
                if (addr_q.size() == 0) begin
                    $display("FAIL rd_addr: read at %0h, no read expected", mem_rd_addr);
                end else begin
                    mon_addr = addr_q.pop_front();
                    if (mem_rd_addr !== mon_addr)
                        $display("FAIL rd_addr: got %0h want %0h", mem_rd_addr, mon_addr);
                    else passed++;
                end
            end
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last)
                    $display("FAIL stall_hold: got v=%b d=%0h l=%b want v=1 d=%0h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                else passed++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat: unexpected beat d=%0h l=%b", m_axis_tdata, m_axis_tlast);
                end else begin
                    mon_beat = exp_q.pop_front();
                    if ({m_axis_tdata, m_axis_tlast} !== mon_beat)
                        $display("FAIL beat: got d=%0h l=%b want d=%0h l=%b",
                                 m_axis_tdata, m_axis_tlast, mon_beat.data, mon_beat.last);
                    else passed++;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

    int w_first_rd, w_first_vld, w_done, w_run_max, w_beats, w_first_beat, w_last_beat, w_max_occ;
    bit w_timeout;

    function automatic bit pat(input int k);
        if (k >= 6 && k < 11) return 1'b0;
        return (k % 3) == 0;
    endfunction

    task automatic queue_frame(input logic [AW-1:0] a, input logic [LW-1:0] l);
        for (int i = 0; i <= int'(l); i++) begin
            logic [AW-1:0] ai;
            beat_t eb;
            ai = a + AW'(i);
            eb.data = mem[ai];
            eb.last = (i == int'(l));
            addr_q.push_back(ai);
            exp_q.push_back(eb);
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, output int t);
        queue_frame(a, l);
        @(posedge clk); #1;
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        t = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin t = cyc; break; end
        end
        if (t < 0) begin
            checks++;
            $display("FAIL cmd_accept: cmd_ready never seen within 50 cycles, want accept");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic watch(input int budget, input bit bp, input int stop_beats);
        int run;
        int rd_cnt;
        run = 0; rd_cnt = 0;
        w_first_rd = -1; w_first_vld = -1; w_done = -1; w_run_max = 0;
        w_beats = 0; w_first_beat = -1; w_last_beat = -1; w_max_occ = 0; w_timeout = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rd_cnt - w_beats > w_max_occ) w_max_occ = rd_cnt - w_beats;
            if (mem_rd_en) begin
                rd_cnt++; run++;
                if (w_first_rd < 0) w_first_rd = cyc;
                if (run > w_run_max) w_run_max = run;
            end else begin
                run = 0;
            end
            if (m_axis_tvalid && w_first_vld < 0) w_first_vld = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                w_beats++;
                if (w_first_beat < 0) w_first_beat = cyc;
                w_last_beat = cyc;
            end
            if (done) begin w_done = cyc; w_timeout = 1'b0; break; end
            if (stop_beats > 0 && w_beats == stop_beats) begin w_timeout = 1'b0; break; end
            @(posedge clk); #1;
            if (bp) m_axis_tready = pat(k);
        end
        if (w_timeout) begin
            checks++;
            $display("FAIL watch_timeout: no done within %0d cycles, beats=%0d", budget, w_beats);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, mem_rd_en, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, done} !== 7'b1000000)
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {cmd_ready, mem_rd_en, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, done});
        else passed++;
        checks++;
        if (m_axis_tdata !== '0 || mem_rd_addr !== '0)
            $display("FAIL reset_data: got tdata=%0h rd_addr=%0h want 0 0", m_axis_tdata, mem_rd_addr);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        int t;
        m_axis_tready = 1'b1;
        send_cmd(8'h10, 8'd0, t);
        watch(50, 1'b0, 0);
        checks++;
        if (w_first_rd !== t + 1) $display("FAIL single_rd_lat: got %0d want %0d", w_first_rd, t + 1);
        else passed++;
        checks++;
        if (w_first_vld !== t + 3) $display("FAIL single_vld_lat: got %0d want %0d", w_first_vld, t + 3);
        else passed++;
        checks++;
        if (w_done !== t + 4) $display("FAIL single_done: got %0d want %0d", w_done, t + 4);
        else passed++;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL single_idle: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        else passed++;
        checks++;
        if (w_beats !== 1) $display("FAIL single_beats: got %0d want 1", w_beats);
        else passed++;
    endtask

    task automatic test_full_rate();
        int t;
        m_axis_tready = 1'b1;
        send_cmd(8'h00, 8'd7, t);
        watch(100, 1'b0, 0);
        checks++;
        if (w_run_max !== 8) $display("FAIL full_rd_run: got %0d want 8", w_run_max);
        else passed++;
        checks++;
        if (w_beats !== 8 || w_last_beat - w_first_beat !== 7)
            $display("FAIL full_no_bubble: got beats=%0d span=%0d want 8 7", w_beats, w_last_beat - w_first_beat);
        else passed++;
        checks++;
        if (w_first_beat !== t + 3) $display("FAIL full_first_beat: got %0d want %0d", w_first_beat, t + 3);
        else passed++;
        checks++;
        if (exp_q.size() !== 0) $display("FAIL full_drained: got %0d left want 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        int t;
        m_axis_tready = 1'b1;
        send_cmd(8'h00, 8'd7, t);
        watch(300, 1'b1, 0);
        m_axis_tready = 1'b1;
        checks++;
        if (w_beats !== 8) $display("FAIL bp_beats: got %0d want 8", w_beats);
        else passed++;
        checks++;
        if (w_max_occ > 2) $display("FAIL bp_occupancy: got %0d want <=2", w_max_occ);
        else passed++;
        checks++;
        if (exp_q.size() !== 0 || addr_q.size() !== 0)
            $display("FAIL bp_drained: got beats=%0d addrs=%0d left want 0 0", exp_q.size(), addr_q.size());
        else passed++;
    endtask

    task automatic test_wrap();
        int t;
        mem[8'hFE] = 8'hC1; mem[8'hFF] = 8'hC2; mem[8'h00] = 8'h9E; mem[8'h01] = 8'h9F;
        m_axis_tready = 1'b1;
        send_cmd(8'hFE, 8'd3, t);
        watch(100, 1'b0, 0);
        checks++;
        if (w_beats !== 4) $display("FAIL wrap_beats: got %0d want 4", w_beats);
        else passed++;
        checks++;
        if (exp_q.size() !== 0 || addr_q.size() !== 0)
            $display("FAIL wrap_drained: got beats=%0d addrs=%0d left want 0 0", exp_q.size(), addr_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int t;
        m_axis_tready = 1'b1;
        send_cmd(8'h00, 8'd15, t);
        watch(100, 1'b0, 5);
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, mem_rd_en, m_axis_tvalid, m_axis_tlast, busy, done} !== 6'b100000 ||
            m_axis_tdata !== '0 || mem_rd_addr !== '0)
            $display("FAIL midrst_outputs: got ctrl=%b tdata=%0h addr=%0h want 100000 0 0",
                     {cmd_ready, mem_rd_en, m_axis_tvalid, m_axis_tlast, busy, done}, m_axis_tdata, mem_rd_addr);
        else passed++;
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0)
            $display("FAIL midrst_release: got cmd_ready=%b busy=%b tvalid=%b want 1 0 0",
                     cmd_ready, busy, m_axis_tvalid);
        else passed++;
        mon_en = 1'b1;
        send_cmd(8'h40, 8'd1, t);
        watch(100, 1'b0, 0);
        checks++;
        if (w_beats !== 2 || exp_q.size() !== 0)
            $display("FAIL midrst_frame: got beats=%0d left=%0d want 2 0", w_beats, exp_q.size());
        else passed++;
    endtask

    task automatic test_held_cmd();
        int t1;
        int dcyc;
        int early;
        m_axis_tready = 1'b1;
        queue_frame(8'h20, 8'd2);
        @(posedge clk); #1;
        cmd_addr = 8'h20; cmd_len = 8'd2; cmd_valid = 1'b1;
        t1 = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin t1 = cyc; break; end
        end
        @(posedge clk); #1;
        queue_frame(8'h30, 8'd1);
        cmd_addr = 8'h30; cmd_len = 8'd1;
        early = 0; dcyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin dcyc = cyc; break; end
            if (cmd_ready) early++;
        end
        checks++;
        if (t1 < 0 || dcyc < 0 || early !== 0)
            $display("FAIL held_holdoff: got accept1=%0d done=%0d early_ready=%0d want accept, done, 0",
                     t1, dcyc, early);
        else passed++;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL held_ready_at_done: got %b want 1", cmd_ready);
        else passed++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1)
            $display("FAIL held_second_start: got busy=%b rd_en=%b want 1 1", busy, mem_rd_en);
        else passed++;
        watch(100, 1'b0, 0);
        checks++;
        if (exp_q.size() !== 0 || addr_q.size() !== 0)
            $display("FAIL held_drained: got beats=%0d addrs=%0d left want 0 0", exp_q.size(), addr_q.size());
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        cmd_valid = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        mem[8'h10] = 8'hA5;

        test_reset();
        test_single();
        test_full_rate();
        test_backpressure();
        test_wrap();
        test_reset_mid_frame();
        test_held_cmd();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
